conv2_sched: RTL and testbench
==============================

# conv2_sched

Sequencing controller for the `conv2` 2-D convolution datapath. On a `start` pulse it slides a SIZEKer×SIZEKer window over a SIZE×SIZE input matrix in row-major order. For every output pixel it drives the input and kernel tap addresses plus the multiply-accumulate controls. It then issues one write strobe for the finished output pixel and pulses `done` when the whole (SIZE−SIZEKer+1)² output matrix has been produced.

## Interface
- SIZE, 7, input matrix dimension (square); legal range SIZEKer..255
- SIZEKer, 3, kernel dimension (square); legal range 1..SIZE
- WIDTH_BIT, 8, datapath word width; carried for the `conv2` parameter set, no arithmetic use here
- AW, derived = max(1, $clog2(SIZE)), address field width
- clock  in  1  single clock, rising edge
- nreset  in  1  asynchronous active-low reset
- start  in  1  begin a full convolution; sampled only in IDLE
- hold  in  1  stall; freezes all state and counters while high
- busy  out  1  high in ACC and WRITE
- done  out  1  one-cycle pulse when the last output pixel has been written
- in_row, in_col  out  AW each  input-matrix tap address = window origin + kernel offset
- ker_row, ker_col  out  AW each  kernel tap address
- mac_en  out  1  accumulate the product at the current tap
- mac_first  out  1  qualifies `mac_en` on tap 0: accumulator loads the product instead of adding it
- out_we  out  1  write the accumulator to the output matrix
- out_row, out_col  out  AW each  output pixel address, valid with `out_we`

## Operation
- OUT = SIZE−SIZEKer+1 and TAPS = SIZEKer².
- FSM states are IDLE, ACC, WRITE and DONE. All state and address registers are registered. Outputs decode from the registers with no input-to-output combinational path, except the `hold` gating of `mac_en`/`out_we`.
- **IDLE**: when `start`=1 and `hold`=0, go to ACC. The window origin (wr, wc) and the tap (ki, kj) all load 0.
- **ACC**: `mac_en`=1. `mac_first`=1 only when ki=kj=0. `in_row`=wr+ki, `in_col`=wc+kj, `ker_row`=ki, `ker_col`=kj. Taps advance row-major, with kj fastest. After tap (SIZEKer−1, SIZEKer−1), go to WRITE.
- **WRITE**: `out_we`=1, `out_row`=wr, `out_col`=wc. Advance the window row-major, with wc fastest and wrap at OUT−1.
  - If (wr, wc) was (OUT−1, OUT−1), go to DONE.
  - Otherwise go to ACC, with ki and kj reset to 0.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` is ignored in ACC, WRITE and DONE. There is no queuing.
- `hold`=1 in any state:
  - next state and all counters are held;
  - `mac_en`, `mac_first` and `out_we` are forced to 0;
  - address outputs keep their values;
  - `done` stays asserted in DONE until the cycle `hold` drops, so it is pulsed exactly once;
  - `hold` in IDLE also blocks `start`.
- All counters are exact. In-range addresses never exceed SIZE−1, so there is no overflow.

## Timing
- Reset (`nreset`=0, asynchronous): state goes to IDLE, and every output and counter goes to 0. This applies immediately, including mid-run. After release, the block waits for a new `start`.
- Take `start` sampled high in IDLE at edge t.
  - Cycle t+1 is ACC with tap 0 of pixel (0,0).
  - Each pixel takes TAPS ACC cycles followed by 1 WRITE cycle.
  - The first `out_we` is at cycle t+TAPS+1.
  - The last `out_we` is at cycle t+OUT²·(TAPS+1).
  - `done` follows at cycle t+OUT²·(TAPS+1)+1.
  - IDLE is reached the cycle after `done`.
- Defaults: 25 pixels × 10 cycles. The first WRITE is at t+10, the last WRITE at t+250, `done` at t+251, and the earliest restart is sampled at t+252.
- Each stalled cycle extends every later event by exactly one cycle.
- The accumulator downstream is updated on the same edge at which `mac_en` is sampled. It is valid for writing on the WRITE cycle.

## Test plan
- **Reset values**: assert `nreset`=0 with the clock stopped → all outputs read 0 and state is IDLE. Release it and give no `start` for 20 cycles → `busy`=0 and `out_we`=0 throughout.
- **Full default run**: `start` pulse at t → `out_we` exactly 25 times, at t+10k (k=1..25), with (`out_row`, `out_col`) in row-major order from (0,0) to (4,4). Check:
  - 225 `mac_en` cycles in total;
  - exactly 25 `mac_first` cycles;
  - `in_row`/`in_col` of pixel (2,3) tap (1,2) = (3,5);
  - `done` only at t+251.
- **Hold**: assert `hold` for 3 cycles starting on tap 4 of pixel (1,1) → `mac_en`=0 during the stall and addresses frozen. Tap 4 is re-presented after release, and `done` shifts to t+254. Also hold on the DONE cycle → `done` stays high until release and is counted once.
- **Start while busy**: pulse `start` again at t+50 and at t+251 → ignored, and exactly 25 writes and 1 `done`. A `start` at t+252 begins a second run whose first WRITE is at t+262.
- **Reset mid-run**: drop `nreset` at t+137 → outputs go to 0 asynchronously. After release with no `start` → no further `out_we`. A new `start` → a full 25-pixel run from (0,0).
- **Edge parameters**:
  - SIZE=SIZEKer=3 → one pixel, 9 taps, WRITE at t+10 with (0,0), `done` at t+11.
  - SIZEKer=1, SIZE=4 → 16 pixels of 2 cycles each, with `mac_first` set on every ACC cycle.

Source files
------------

// File: rtl/conv2_sched.sv
// conv2_sched -- sequencing controller for the conv2 2-D convolution datapath.
//
// On a start pulse it slides a SIZEKer x SIZEKer window over a SIZE x SIZE
// input matrix in row-major order. Each output pixel takes SIZEKer^2
// accumulate cycles and is followed by one write cycle. After the last pixel,
// done pulses once and the block returns to idle.
//
// Ports
//   clock               rising-edge clock
//   nreset              asynchronous active-low reset
//   start               begin a full convolution (honoured only in IDLE)
//   hold                stall: freezes state and counters, gates mac_en/out_we
//   busy                high while accumulating or writing
//   done                one pulse (stretched by hold) after the last write
//   in_row, in_col      input tap address = window origin + kernel offset
//   ker_row, ker_col    kernel tap address
//   mac_en              accumulate product at current tap
//   mac_first           tap 0: accumulator loads instead of adds
//   out_we              write accumulator to output matrix
//   out_row, out_col    output pixel address, valid with out_we
module conv2_sched #(
    parameter int SIZE      = 7,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8,
    localparam int AW       = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] in_row,
    output logic [AW-1:0] in_col,
    output logic [AW-1:0] ker_row,
    output logic [AW-1:0] ker_col,
    output logic          mac_en,
    output logic          mac_first,
    output logic          out_we,
    output logic [AW-1:0] out_row,
    output logic [AW-1:0] out_col
);

    localparam int OUT = SIZE - SIZEKer + 1;
    localparam logic [AW-1:0] KLast = AW'(SIZEKer - 1);
    localparam logic [AW-1:0] OLast = AW'(OUT - 1);

    // Reject parameter sets the address arithmetic cannot represent.
    if (SIZEKer < 1 || SIZEKer > SIZE || SIZE > 255 || WIDTH_BIT < 1) begin : gBadParams
        $error("conv2_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ACC, WRITE, DONE} stateT;

    stateT         state, stateNext;
    logic [AW-1:0] winRow, winCol, tapRow, tapCol;
    logic [AW-1:0] winRowNext, winColNext, tapRowNext, tapColNext;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            winRow <= '0;
            winCol <= '0;
            tapRow <= '0;
            tapCol <= '0;
        end else begin
            state  <= stateNext;
            winRow <= winRowNext;
            winCol <= winColNext;
            tapRow <= tapRowNext;
            tapCol <= tapColNext;
        end
    end

    // Addresses come straight from the registers, so a stall leaves them
    // frozen and the tap is re-presented unchanged when hold drops.
    assign in_row  = winRow + tapRow;
    assign in_col  = winCol + tapCol;
    assign ker_row = tapRow;
    assign ker_col = tapCol;
    assign out_row = winRow;
    assign out_col = winCol;

    always_comb begin
        stateNext  = state;
        winRowNext = winRow;
        winColNext = winCol;
        tapRowNext = tapRow;
        tapColNext = tapCol;
        busy       = 1'b0;
        done       = 1'b0;
        mac_en     = 1'b0;
        mac_first  = 1'b0;
        out_we     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !hold) begin
                    stateNext  = ACC;
                    winRowNext = '0;
                    winColNext = '0;
                    tapRowNext = '0;
                    tapColNext = '0;
                end
            end

            ACC: begin
                busy      = 1'b1;
                mac_en    = !hold;
                mac_first = !hold && (tapRow == '0) && (tapCol == '0);
                if (!hold) begin
                    if (tapCol == KLast) begin
                        tapColNext = '0;
                        if (tapRow == KLast) begin
                            tapRowNext = '0;
                            stateNext  = WRITE;
                        end else begin
                            tapRowNext = tapRow + 1'b1;
                        end
                    end else begin
                        tapColNext = tapCol + 1'b1;
                    end
                end
            end

            WRITE: begin
                busy   = 1'b1;
                out_we = !hold;
                if (!hold) begin
                    tapRowNext = '0;
                    tapColNext = '0;
                    stateNext  = ACC;
                    if (winCol == OLast) begin
                        winColNext = '0;
                        if (winRow == OLast) begin
                            // Last pixel written: window wraps back to the origin.
                            winRowNext = '0;
                            stateNext  = DONE;
                        end else begin
                            winRowNext = winRow + 1'b1;
                        end
                    end else begin
                        winColNext = winCol + 1'b1;
                    end
                end
            end

            DONE: begin
                // Held high across a stall so the pulse is seen exactly once.
                done = 1'b1;
                if (!hold) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv2_sched.sv
module tb_conv2_sched;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       macEn;
        logic       macFirst;
        logic       outWe;
        logic [7:0] inRow;
        logic [7:0] inCol;
        logic [7:0] kerRow;
        logic [7:0] kerCol;
        logic [7:0] outRow;
        logic [7:0] outCol;
    } obsT;

    // kind: 0 = accumulate tap, 1 = write pixel, 2 = done
    typedef struct {
        int dut;
        int cyc;
        int kind;
        int a;
        int b;
        int c;
        int e;
        bit first;
    } evT;

    logic clk = 1'b0;
    logic clkOn = 1'b0;
    logic nreset = 1'b1;
    logic startV [3];
    logic holdV [3];
    int   cyc = 0;

    evT   expQ [$];
    int   total = 0;
    int   bad = 0;
    int   macCnt [3];
    int   firstCnt [3];
    int   weCnt [3];
    int   doneCnt [3];
    logic prevHold [3];
    obsT  prevObs [3];
    obsT  obs [3];

    // DUT 0: default 7x7 / 3x3
    logic b0, dn0, me0, mf0, we0;
    logic [2:0] inR0, inC0, kR0, kC0, oR0, oC0;
    // DUT 1: 3x3 / 3x3 (single pixel)
    logic b1, dn1, me1, mf1, we1;
    logic [1:0] inR1, inC1, kR1, kC1, oR1, oC1;
    // DUT 2: 4x4 / 1x1
    logic b2, dn2, me2, mf2, we2;
    logic [1:0] inR2, inC2, kR2, kC2, oR2, oC2;

    conv2_sched #(.SIZE(7), .SIZEKer(3), .WIDTH_BIT(8)) dut0 (
        .clock(clk), .nreset(nreset), .start(startV[0]), .hold(holdV[0]),
        .busy(b0), .done(dn0), .in_row(inR0), .in_col(inC0),
        .ker_row(kR0), .ker_col(kC0), .mac_en(me0), .mac_first(mf0),
        .out_we(we0), .out_row(oR0), .out_col(oC0));

    conv2_sched #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(8)) dut1 (
        .clock(clk), .nreset(nreset), .start(startV[1]), .hold(holdV[1]),
        .busy(b1), .done(dn1), .in_row(inR1), .in_col(inC1),
        .ker_row(kR1), .ker_col(kC1), .mac_en(me1), .mac_first(mf1),
        .out_we(we1), .out_row(oR1), .out_col(oC1));

    conv2_sched #(.SIZE(4), .SIZEKer(1), .WIDTH_BIT(8)) dut2 (
        .clock(clk), .nreset(nreset), .start(startV[2]), .hold(holdV[2]),
        .busy(b2), .done(dn2), .in_row(inR2), .in_col(inC2),
        .ker_row(kR2), .ker_col(kC2), .mac_en(me2), .mac_first(mf2),
        .out_we(we2), .out_row(oR2), .out_col(oC2));

    assign obs[0] = {b0, dn0, me0, mf0, we0, {5'd0, inR0}, {5'd0, inC0},
                     {5'd0, kR0}, {5'd0, kC0}, {5'd0, oR0}, {5'd0, oC0}};
    assign obs[1] = {b1, dn1, me1, mf1, we1, {6'd0, inR1}, {6'd0, inC1},
                     {6'd0, kR1}, {6'd0, kC1}, {6'd0, oR1}, {6'd0, oC1}};
    assign obs[2] = {b2, dn2, me2, mf2, we2, {6'd0, inR2}, {6'd0, inC2},
                     {6'd0, kR2}, {6'd0, kC2}, {6'd0, oR2}, {6'd0, oC2}};

    initial begin
        wait (clkOn);
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // A stall delays every event scheduled at or after its first cycle.
    function automatic int shiftCyc(int c, int hs, int hl);
        return (hl > 0 && c >= hs) ? c + hl : c;
    endfunction

    // Reference model: the whole run as an ordered list of observable events.
    task automatic pushRun(int d, int size, int ker, int t, int hs, int hl);
        int out;
        int n;
        evT ev;
        out = size - ker + 1;
        n = 0;
        for (int r = 0; r < out; r++) begin
            for (int c = 0; c < out; c++) begin
                for (int i = 0; i < ker; i++) begin
                    for (int j = 0; j < ker; j++) begin
                        ev.dut = d; ev.kind = 0;
                        ev.cyc = shiftCyc(t + 1 + n, hs, hl);
                        ev.a = r + i; ev.b = c + j; ev.c = i; ev.e = j;
                        ev.first = (i == 0 && j == 0);
                        expQ.push_back(ev);
                        n++;
                    end
                end
                ev.dut = d; ev.kind = 1;
                ev.cyc = shiftCyc(t + 1 + n, hs, hl);
                ev.a = r; ev.b = c; ev.c = 0; ev.e = 0; ev.first = 1'b0;
                expQ.push_back(ev);
                n++;
            end
        end
        ev.dut = d; ev.kind = 2;
        ev.cyc = shiftCyc(t + 1 + n, hs, hl);
        ev.a = 0; ev.b = 0; ev.c = 0; ev.e = 0; ev.first = 1'b0;
        expQ.push_back(ev);
    endtask

    task automatic sample(int d);
        obsT o;
        evT  ev;
        bit  ok;
        o = obs[d];
        if (holdV[d]) begin
            total++;
            if (o.macEn || o.macFirst || o.outWe) begin
                bad++;
                $display("FAIL hold_gate d=%0d cyc=%0d: mac=%0b first=%0b we=%0b, want all 0",
                         d, cyc, o.macEn, o.macFirst, o.outWe);
            end
        end
        if (prevHold[d]) begin
            total++;
            if ({o.inRow, o.inCol, o.kerRow, o.kerCol, o.outRow, o.outCol} !=
                {prevObs[d].inRow, prevObs[d].inCol, prevObs[d].kerRow,
                 prevObs[d].kerCol, prevObs[d].outRow, prevObs[d].outCol} ||
                (prevObs[d].done && !o.done)) begin
                bad++;
                $display("FAIL hold_freeze d=%0d cyc=%0d: in=(%0d,%0d) out=(%0d,%0d) done=%0b, want in=(%0d,%0d) out=(%0d,%0d) done=%0b",
                         d, cyc, o.inRow, o.inCol, o.outRow, o.outCol, o.done,
                         prevObs[d].inRow, prevObs[d].inCol, prevObs[d].outRow,
                         prevObs[d].outCol, prevObs[d].done);
            end
        end
        if (o.macEn) macCnt[d]++;
        if (o.macFirst) firstCnt[d]++;
        if (o.outWe) weCnt[d]++;
        if (o.done && !prevObs[d].done) doneCnt[d]++;

        if (o.macEn || o.outWe || (o.done && !holdV[d])) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected d=%0d cyc=%0d: mac=%0b we=%0b done=%0b, want no activity",
                         d, cyc, o.macEn, o.outWe, o.done);
            end else begin
                ev = expQ.pop_front();
                ok = (ev.dut == d) && (ev.cyc == cyc);
                case (ev.kind)
                    0: ok = ok && o.macEn && !o.outWe && !o.done && o.busy &&
                            (o.macFirst == ev.first) &&
                            (int'(o.inRow) == ev.a) && (int'(o.inCol) == ev.b) &&
                            (int'(o.kerRow) == ev.c) && (int'(o.kerCol) == ev.e);
                    1: ok = ok && o.outWe && !o.macEn && !o.macFirst && !o.done && o.busy &&
                            (int'(o.outRow) == ev.a) && (int'(o.outCol) == ev.b);
                    default: ok = ok && o.done && !o.busy && !o.macEn && !o.outWe;
                endcase
                if (!ok) begin
                    bad++;
                    $display("FAIL event d=%0d cyc=%0d: busy=%0b mac=%0b first=%0b we=%0b done=%0b in=(%0d,%0d) ker=(%0d,%0d) out=(%0d,%0d); want d=%0d cyc=%0d kind=%0d a=%0d b=%0d c=%0d e=%0d first=%0b",
                             d, cyc, o.busy, o.macEn, o.macFirst, o.outWe, o.done,
                             o.inRow, o.inCol, o.kerRow, o.kerCol, o.outRow, o.outCol,
                             ev.dut, ev.cyc, ev.kind, ev.a, ev.b, ev.c, ev.e, ev.first);
                end
            end
        end
        prevHold[d] = holdV[d];
        prevObs[d] = o;
    endtask

    // Monitor: samples every DUT mid-cycle, away from both clock edges.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 3; d++) sample(d);
        end
    end

    task automatic idleCheck(int n);
        repeat (n) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d].busy || obs[d].outWe) begin
                    bad++;
                    $display("FAIL idle d=%0d cyc=%0d: busy=%0b we=%0b, want 0 0",
                             d, cyc, obs[d].busy, obs[d].outWe);
                end
            end
        end
    endtask

    // One run started at the current negedge. hsOff/hl place one stall window
    // relative to the start cycle; s1/s2 are extra start pulses (0 = none).
    task automatic runOne(int d, int size, int ker, int hsOff, int hl, int s1, int s2);
        int t;
        int hs;
        int out;
        int taps;
        int budget;
        out = size - ker + 1;
        taps = ker * ker;
        macCnt[d] = 0; firstCnt[d] = 0; weCnt[d] = 0; doneCnt[d] = 0;
        startV[d] = 1'b1;
        t = cyc;
        hs = (hl > 0) ? t + hsOff : 0;
        pushRun(d, size, ker, t, hs, hl);
        budget = out * out * (taps + 1) + hl + 20;
        while (expQ.size() > 0 && budget > 0) begin
            @(negedge clk);
            startV[d] = (cyc == t + s1) || (cyc == t + s2);
            holdV[d] = (hl > 0) && (cyc >= hs) && (cyc < hs + hl);
            budget--;
        end
        startV[d] = 1'b0;
        holdV[d] = 1'b0;
        check("drain_events", expQ.size(), 0);
        expQ.delete();
        check("mac_en_count", macCnt[d], out * out * taps);
        check("mac_first_count", firstCnt[d], out * out);
        check("out_we_count", weCnt[d], out * out);
        check("done_count", doneCnt[d], 1);
    endtask

    initial begin
        int t;
        for (int d = 0; d < 3; d++) begin
            startV[d] = 1'b0;
            holdV[d] = 1'b0;
            prevHold[d] = 1'b0;
            prevObs[d] = '0;
        end

        // Reset with the clock stopped.
        #2 nreset = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs[d] !== '0) begin
                bad++;
                $display("FAIL reset_values d=%0d: got %h, want 0", d, obs[d]);
            end
        end
        #3 nreset = 1'b1;
        clkOn = 1'b1;
        idleCheck(20);

        // Full run with ignored starts at t+50 and t+251 (DONE), then an
        // immediate restart at t+252 whose first write lands at t+262.
        @(negedge clk);
        runOne(0, 7, 3, 0, 0, 50, 251);
        // Stall 3 cycles on tap 4 of pixel (1,1).
        runOne(0, 7, 3, 65, 3, 0, 0);
        // Stall on the DONE cycle.
        runOne(0, 7, 3, 251, 3, 0, 0);

        // Randomised stalls and stray start pulses.
        repeat (3) begin
            int hsOff;
            int hl;
            int s1;
            int s2;
            hsOff = int'($urandom_range(1, 250));
            hl = int'($urandom_range(1, 4));
            s1 = int'($urandom_range(1, 240));
            s2 = int'($urandom_range(1, 240));
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
            runOne(0, 7, 3, hsOff, hl, s1, s2);
        end

        // Reset in the middle of a run.
        @(negedge clk);
        startV[0] = 1'b1;
        t = cyc;
        pushRun(0, 7, 3, t, 0, 0);
        @(negedge clk);
        startV[0] = 1'b0;
        while (cyc < t + 137) @(negedge clk);
        #3 nreset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs[d] !== '0) begin
                bad++;
                $display("FAIL reset_async d=%0d: got %h, want 0", d, obs[d]);
            end
        end
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        idleCheck(20);
        @(negedge clk);
        runOne(0, 7, 3, 0, 0, 0, 0);

        // Edge parameter sets.
        @(negedge clk);
        runOne(1, 3, 3, 0, 0, 0, 0);
        @(negedge clk);
        runOne(2, 4, 1, 0, 0, 0, 0);
        @(negedge clk);
        runOne(2, 4, 1, 5, 2, 0, 0);

        idleCheck(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
